rf_scoreboard: RTL and testbench

Register-file scoreboard and write-port arbiter between the decode stage and the 16-entry, 32-bit integer register file (x0 hard-wired to zero). It tracks outstanding writes per architectural register and gates instruction issue on RAW and write-count hazards. It also arbitrates the EXU and LSU writeback streams onto the register file's single write port. It replaces point-compare hazard checks against individual stage destination registers with per-register pending counters.

---
 rtl/rf_scoreboard_pkg.sv | 23 ++
 rtl/rf_wb_arbiter.sv | 49 ++++
 rtl/rf_scoreboard.sv | 113 +++++++++++
 tb/tb_rf_scoreboard.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_scoreboard_pkg.sv
// Shared parameters and types for the register-file scoreboard slice.
package rf_scoreboard_pkg;

  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 2;

  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_EXU,
    WB_LSU
  } wb_src_e;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter.sv
// Fixed-priority (LSU over EXU) arbiter driving the register file's single
// write port combinationally; writebacks to x0 are accepted and dropped.
module rf_wb_arbiter
  import rf_scoreboard_pkg::*;
(
  input  logic          i_flush,
  input  wb_req_t       i_exu_req,
  input  wb_req_t       i_lsu_req,
  output logic          o_exu_ready,
  output logic          o_lsu_ready,
  output logic          o_rf_wen,
  output logic [AW-1:0] o_rf_waddr,
  output logic [DW-1:0] o_rf_wdata
);

  wb_src_e w_src;

  assign o_lsu_ready = !i_flush;
  assign o_exu_ready = !i_flush && !i_lsu_req.valid;

  always_comb begin
    w_src = WB_NONE;
    if (!i_flush && i_lsu_req.valid) begin
      w_src = WB_LSU;
    end else if (!i_flush && i_exu_req.valid) begin
      w_src = WB_EXU;
    end
  end

  always_comb begin
    o_rf_wen   = 1'b0;
    o_rf_waddr = '0;
    o_rf_wdata = '0;
    case (w_src)
      WB_LSU: begin
        o_rf_wen   = (i_lsu_req.rd != '0);
        o_rf_waddr = i_lsu_req.rd;
        o_rf_wdata = i_lsu_req.data;
      end
      WB_EXU: begin
        o_rf_wen   = (i_exu_req.rd != '0);
        o_rf_waddr = i_exu_req.rd;
        o_rf_wdata = i_exu_req.data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with issue gating and writeback
// arbitration. Optional same-cycle bypass under `RF_SB_BYPASS_EN.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [AW-1:0] iss_rs1,
  input  logic [AW-1:0] iss_rs2,
  input  logic [AW-1:0] iss_rd,
  input  logic          iss_wen,
  input  logic          exu_wb_valid,
  output logic          exu_wb_ready,
  input  logic [AW-1:0] exu_wb_rd,
  input  logic [DW-1:0] exu_wb_data,
  input  logic          lsu_wb_valid,
  output logic          lsu_wb_ready,
  input  logic [AW-1:0] lsu_wb_rd,
  input  logic [DW-1:0] lsu_wb_data,
  input  logic          flush,
  output logic          rf_wen,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
`ifdef RF_SB_BYPASS_EN
  output logic          byp1_hit,
  output logic          byp2_hit,
  output logic [DW-1:0] byp_data,
`endif
  output logic          sb_busy,
  output logic          sb_err
);

  logic [CW-1:0] r_cnt [1:NREG-1];
  logic          r_err;
  logic [CW-1:0] w_cnt [NREG];
  logic          w_clr1;
  logic          w_clr2;
  logic          w_fire;
  logic          w_busy;
  wb_req_t       w_exu_req;
  wb_req_t       w_lsu_req;

  assign w_exu_req = '{valid: exu_wb_valid, rd: exu_wb_rd, data: exu_wb_data};
  assign w_lsu_req = '{valid: lsu_wb_valid, rd: lsu_wb_rd, data: lsu_wb_data};

  rf_wb_arbiter u_arb (
    .i_flush     (flush),
    .i_exu_req   (w_exu_req),
    .i_lsu_req   (w_lsu_req),
    .o_exu_ready (exu_wb_ready),
    .o_lsu_ready (lsu_wb_ready),
    .o_rf_wen    (rf_wen),
    .o_rf_waddr  (rf_waddr),
    .o_rf_wdata  (rf_wdata)
  );

  // x0 reads as a permanently clear counter so hazard lookups need no guard.
  always_comb begin
    w_cnt[0] = '0;
    w_busy   = 1'b0;
    for (int unsigned i = 1; i < NREG; i++) begin
      w_cnt[i] = r_cnt[i];
      w_busy   = w_busy | (r_cnt[i] != '0);
    end
  end

`ifdef RF_SB_BYPASS_EN
  logic w_byp1;
  logic w_byp2;
  assign w_byp1   = (iss_rs1 != '0) && (w_cnt[iss_rs1] == CW'(1)) && rf_wen && (rf_waddr == iss_rs1);
  assign w_byp2   = (iss_rs2 != '0) && (w_cnt[iss_rs2] == CW'(1)) && rf_wen && (rf_waddr == iss_rs2);
  assign byp1_hit = w_byp1;
  assign byp2_hit = w_byp2;
  assign byp_data = rf_wdata;
  assign w_clr1   = (w_cnt[iss_rs1] == '0) || w_byp1;
  assign w_clr2   = (w_cnt[iss_rs2] == '0) || w_byp2;
`else
  assign w_clr1   = (w_cnt[iss_rs1] == '0);
  assign w_clr2   = (w_cnt[iss_rs2] == '0);
`endif

  assign iss_ready = !flush && w_clr1 && w_clr2 &&
                     !(iss_wen && (iss_rd != '0) && (w_cnt[iss_rd] == CNT_MAX));
  assign w_fire    = iss_valid && iss_ready && iss_wen && (iss_rd != '0);
  assign sb_busy   = w_busy;
  assign sb_err    = r_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (flush) begin
          r_cnt[i] <= '0;
        end else if (w_fire && (iss_rd == AW'(i)) && !(rf_wen && (rf_waddr == AW'(i)))) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else if (rf_wen && (rf_waddr == AW'(i)) && !(w_fire && (iss_rd == AW'(i))) &&
                     (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
      if (rf_wen && (w_cnt[rf_waddr] == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard with a per-cycle behavioural model check.
`timescale 1ns/1ps
module tb_rf_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        iss_valid, iss_ready, iss_wen;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd;
  logic        exu_wb_valid, exu_wb_ready;
  logic [3:0]  exu_wb_rd;
  logic [31:0] exu_wb_data;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [3:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        flush;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_busy, sb_err;
`ifdef RF_SB_BYPASS_EN
  logic        byp1_hit, byp2_hit;
  logic [31:0] byp_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  int mcnt [16];
  bit merr;

  rf_scoreboard dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_wen(iss_wen),
    .exu_wb_valid(exu_wb_valid), .exu_wb_ready(exu_wb_ready),
    .exu_wb_rd(exu_wb_rd), .exu_wb_data(exu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .flush(flush),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef RF_SB_BYPASS_EN
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp_data(byp_data),
`endif
    .sb_busy(sb_busy), .sb_err(sb_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic iss(input bit v, input logic [3:0] r1, input logic [3:0] r2,
                     input logic [3:0] rd, input bit wen);
    iss_valid = v; iss_rs1 = r1; iss_rs2 = r2; iss_rd = rd; iss_wen = wen;
  endtask

  task automatic exu(input bit v, input logic [3:0] rd, input logic [31:0] d);
    exu_wb_valid = v; exu_wb_rd = rd; exu_wb_data = d;
  endtask

  task automatic lsu(input bit v, input logic [3:0] rd, input logic [31:0] d);
    lsu_wb_valid = v; lsu_wb_rd = rd; lsu_wb_data = d;
  endtask

  task automatic idle();
    iss(0, 0, 0, 0, 0);
    exu(0, 0, 0);
    lsu(0, 0, 0);
    flush = 0;
  endtask

  // Model: a source is clear when nothing is pending on it (optionally when its
  // only pending write is landing right now).
  function automatic bit src_clear(input logic [3:0] rs, input bit wen, input logic [3:0] wa);
    if (rs == 0 || mcnt[rs] == 0) return 1;
`ifdef RF_SB_BYPASS_EN
    if (mcnt[rs] == 1 && wen && wa == rs) return 1;
`endif
    return 0;
  endfunction

  always @(negedge clock) begin
    bit          acc_l, acc_e, e_wen, e_rdy, e_busy, e_fire;
    logic [3:0]  e_addr;
    logic [31:0] e_data;
    if (!reset) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      merr = 0;
      chk("rst_busy", {31'b0, sb_busy}, 0);
      chk("rst_err",  {31'b0, sb_err},  0);
      chk("rst_wen",  {31'b0, rf_wen},  0);
    end else begin
      acc_l  = lsu_wb_valid && !flush;
      acc_e  = exu_wb_valid && !flush && !lsu_wb_valid;
      e_addr = acc_l ? lsu_wb_rd : exu_wb_rd;
      e_data = acc_l ? lsu_wb_data : exu_wb_data;
      e_wen  = (acc_l || acc_e) && e_addr != 0;
      e_rdy  = !flush && src_clear(iss_rs1, e_wen, e_addr) && src_clear(iss_rs2, e_wen, e_addr)
               && !(iss_wen && iss_rd != 0 && mcnt[iss_rd] == 3);
      e_busy = 0;
      foreach (mcnt[i]) if (mcnt[i] != 0) e_busy = 1;
      chk("m_lsu_ready", {31'b0, lsu_wb_ready}, {31'b0, !flush});
      chk("m_exu_ready", {31'b0, exu_wb_ready}, {31'b0, !flush && !lsu_wb_valid});
      chk("m_rf_wen",    {31'b0, rf_wen},       {31'b0, e_wen});
      if (e_wen) begin
        chk("m_rf_waddr", {28'b0, rf_waddr}, {28'b0, e_addr});
        chk("m_rf_wdata", rf_wdata, e_data);
      end
      chk("m_iss_ready", {31'b0, iss_ready}, {31'b0, e_rdy});
      chk("m_busy",      {31'b0, sb_busy},   {31'b0, e_busy});
      chk("m_err",       {31'b0, sb_err},    {31'b0, merr});
`ifdef RF_SB_BYPASS_EN
      chk("m_byp1", {31'b0, byp1_hit},
          {31'b0, iss_rs1 != 0 && mcnt[iss_rs1] == 1 && e_wen && e_addr == iss_rs1});
      chk("m_byp2", {31'b0, byp2_hit},
          {31'b0, iss_rs2 != 0 && mcnt[iss_rs2] == 1 && e_wen && e_addr == iss_rs2});
      if (e_wen) chk("m_byp_data", byp_data, e_data);
`endif
      e_fire = iss_valid && e_rdy && iss_wen && iss_rd != 0;
      if (flush) begin
        foreach (mcnt[i]) mcnt[i] = 0;
      end else begin
        if (e_wen && mcnt[e_addr] == 0) merr = 1;
        if (e_fire && e_wen && iss_rd == e_addr) begin
          // simultaneous issue and retire on one register: net zero
        end else begin
          if (e_wen && mcnt[e_addr] != 0) mcnt[e_addr]--;
          if (e_fire) mcnt[iss_rd]++;
        end
      end
    end
  end

  initial begin
    idle();
    reset = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1;
    #1;
    chk("post_rst_ready", {31'b0, iss_ready}, 1);
    chk("post_rst_busy",  {31'b0, sb_busy},   0);
    chk("post_rst_wen",   {31'b0, rf_wen},    0);

    // RAW hazard on x5
    iss(1, 0, 0, 5, 1); #1;
    chk("raw_first_ready", {31'b0, iss_ready}, 1);
    tick();
    chk("raw_busy", {31'b0, sb_busy}, 1);
    iss(1, 5, 0, 6, 1); #1;
    chk("raw_blocked", {31'b0, iss_ready}, 0);
    tick(); #1;
    chk("raw_still_blocked", {31'b0, iss_ready}, 0);
    exu(1, 5, 32'hDEADBEEF); #1;
    chk("raw_wb_wen",  {31'b0, rf_wen},   1);
    chk("raw_wb_addr", {28'b0, rf_waddr}, 5);
`ifdef RF_SB_BYPASS_EN
    chk("raw_byp_ready", {31'b0, iss_ready}, 1);
    chk("raw_byp1_hit",  {31'b0, byp1_hit},  1);
    tick();
    idle();
`else
    chk("raw_wb_cycle_ready", {31'b0, iss_ready}, 0);
    tick();
    exu(0, 0, 0); #1;
    chk("raw_after_retire_ready", {31'b0, iss_ready}, 1);
    tick();
    idle();
`endif
    exu(1, 6, 32'h0000_0006); tick(); idle();

    // Arbitration
    iss(1, 0, 0, 3, 1); tick();
    iss(1, 0, 0, 4, 1); tick();
    idle();
    exu(1, 3, 32'h3333_3333);
    lsu(1, 4, 32'h4444_4444); #1;
    chk("arb_lsu_ready", {31'b0, lsu_wb_ready}, 1);
    chk("arb_exu_ready", {31'b0, exu_wb_ready}, 0);
    chk("arb_waddr_lsu", {28'b0, rf_waddr},     4);
    tick();
    lsu(0, 0, 0); #1;
    chk("arb_waddr_exu", {28'b0, rf_waddr}, 3);
    chk("arb_wdata_exu", rf_wdata, 32'h3333_3333);
    tick();
    idle(); #1;
    chk("arb_busy_clear", {31'b0, sb_busy}, 0);

    // Counter saturation on x7
    repeat (3) begin iss(1, 0, 0, 7, 1); tick(); end
    #1;
    chk("sat_fourth_blocked", {31'b0, iss_ready}, 0);
    idle();
    exu(1, 7, 32'h7); tick();
    idle();
    iss(1, 0, 0, 7, 1); exu(1, 7, 32'h77); #1;
    chk("sat_issue_retire_ready", {31'b0, iss_ready}, 1);
    tick();
    exu(0, 0, 0); #1;
    chk("sat_refill_ready", {31'b0, iss_ready}, 1);
    tick(); #1;
    chk("sat_full_again", {31'b0, iss_ready}, 0);
    idle();
    repeat (3) begin exu(1, 7, 32'h7); tick(); end
    idle(); #1;
    chk("sat_drained", {31'b0, sb_busy}, 0);

    // Retire with no pending write
    lsu(1, 9, 32'h9999_0000); #1;
    chk("err_rf_wen", {31'b0, rf_wen}, 1);
    chk("err_before", {31'b0, sb_err}, 0);
    tick();
    idle(); #1;
    chk("err_set",  {31'b0, sb_err},  1);
    chk("err_busy", {31'b0, sb_busy}, 0);
    tick();
    chk("err_sticky", {31'b0, sb_err}, 1);

    // Flush
    iss(1, 0, 0, 1, 1); tick();
    iss(1, 0, 0, 2, 1); tick();
    iss(1, 0, 0, 10, 1); tick();
    iss(1, 0, 0, 11, 1); tick();
    flush = 1; exu(1, 1, 32'h1); lsu(1, 2, 32'h2); #1;
    chk("flush_lsu_ready", {31'b0, lsu_wb_ready}, 0);
    chk("flush_exu_ready", {31'b0, exu_wb_ready}, 0);
    chk("flush_iss_ready", {31'b0, iss_ready},    0);
    chk("flush_rf_wen",    {31'b0, rf_wen},       0);
    tick();
    idle(); #1;
    chk("flush_busy_clear", {31'b0, sb_busy}, 0);

    // x0 traffic
    iss(1, 0, 0, 0, 1); exu(1, 0, 32'hFFFF_FFFF); #1;
    chk("x0_ready", {31'b0, iss_ready}, 1);
    chk("x0_wen",   {31'b0, rf_wen},    0);
    tick();
    lsu(1, 0, 32'h1234_5678); tick();
    idle(); #1;
    chk("x0_busy", {31'b0, sb_busy}, 0);

    // Asynchronous reset mid-cycle
    iss(1, 0, 0, 12, 1); tick();
    idle(); #1;
    chk("arst_busy_before", {31'b0, sb_busy}, 1);
    #1 reset = 0;
    #1;
    chk("arst_busy", {31'b0, sb_busy}, 0);
    chk("arst_err",  {31'b0, sb_err},  0);
    @(posedge clock); #1 reset = 1;
    tick(); #1;
    chk("arst_ready_after", {31'b0, iss_ready}, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
